// File: rtl/data_mem_responder_if.sv
// Data-bus handshake between the processor data port and its memory responder.
// The initiator holds Read/Write/Addr/WrData while Waitreq is high.
interface data_mem_responder_if;
    logic        Read;
    logic        Write;
    logic [15:0] Addr;
    logic [15:0] WrData;
    logic [15:0] RdData;
    logic        Waitreq;

    modport master (
        output Read, Write, Addr, WrData,
        input  RdData, Waitreq
    );

    modport slave (
        input  Read, Write, Addr, WrData,
        output RdData, Waitreq
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory plus LED and transfer-counter registers,
// answering each transfer after a fixed number of wait states.
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 12
) (
    input  logic                 Clock,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus,
    output logic [15:0]          Leds
);
    localparam int          Depth   = 1 << ADDR_BITS;
    localparam logic [3:0]  WaitMax = 4'(WAIT_CYCLES);
    localparam logic [15:0] LedAddr = 16'hFFF0;
    localparam logic [15:0] CntAddr = 16'hFFF1;

    logic [15:0] mem [Depth];

    logic [3:0]  cnt;
    logic [17:0] sig;
    logic [17:0] sigQ;
    logic [15:0] rdDataQ;
    logic [15:0] ledQ;
    logic [15:0] xferCnt;
    logic [15:0] readVal;
    logic        req;
    logic        inRange;
    logic        sigChanged;
    logic        done;

    assign req        = bus.Read | bus.Write;
    assign sig        = {bus.Read, bus.Write, bus.Addr};
    assign sigChanged = sig != sigQ;
    assign inRange    = (32'(bus.Addr) >> ADDR_BITS) == 32'd0;
    assign done       = req && (cnt == WaitMax);

    assign bus.Waitreq = req && (cnt != WaitMax);
    assign bus.RdData  = rdDataQ;
    assign Leds        = ledQ;

    // Any write (including Read+Write) returns zero on the read path.
    always_comb begin
        readVal = 16'h0000;
        if (bus.Write)
            readVal = 16'h0000;
        else if (inRange)
            readVal = mem[bus.Addr[ADDR_BITS-1:0]];
        else if (bus.Addr == LedAddr)
            readVal = ledQ;
        else if (bus.Addr == CntAddr)
            readVal = xferCnt;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt     <= 4'd0;
            sigQ    <= 18'd0;
            rdDataQ <= 16'h0000;
            ledQ    <= 16'h0000;
            xferCnt <= 16'h0000;
        end else begin
            sigQ <= sig;
            if (!req) begin
                cnt <= 4'd0;
            end else if (done) begin
                cnt     <= 4'd0;
                xferCnt <= xferCnt + 16'd1;
                if (bus.Write && bus.Addr == LedAddr)
                    ledQ <= bus.WrData;
            end else begin
                // A new request signature counts this edge as its first wait.
                cnt     <= sigChanged ? 4'd1 : cnt + 4'd1;
                rdDataQ <= readVal;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (done && bus.Write && inRange)
            mem[bus.Addr[ADDR_BITS-1:0]] <= bus.WrData;
    end
endmodule
